mainfsm: RTL and testbench

Moore control state machine for the multicycle ARM processor, instantiated inside the `arm` controller alongside the ALU and condition decoders. It steps every instruction through fetch, decode, execute, memory and writeback cycles. From the 2-bit `Op` and 6-bit `Funct` fields it drives the datapath enables and mux selects that set `Adr`, `MemWrite` and register writeback at the processor/memory boundary. Conditional gating (`RegW`/`MemW`/`Branch` against flags) is done downstream in the condition logic, not here.

---
 rtl/mainfsm.sv | 154 +++++++++++++++
 tb/tb_mainfsm.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mainfsm.sv
// Moore control FSM for the multicycle ARM: steps each instruction through fetch/decode/execute/memory/writeback.
// Optional macro MAINFSM_BL_EN adds the LINK state so BL writes the return address to R14 before branching.
module mainfsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       LinkW,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        LINK     = 4'd10,
        UNKNOWN  = 4'd11
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Funct[3:1] never steer the sequence; Funct[4] only matters when BL support is built in.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
`ifdef MAINFSM_BL_EN
                    2'b10:   state_next = Funct[4] ? LINK : BRANCH;
`else
                    2'b10:   state_next = BRANCH;
`endif
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWR:    state_next = FETCH;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
`ifdef MAINFSM_BL_EN
            LINK:     state_next = BRANCH;
`endif
            UNKNOWN:  state_next = FETCH;
            // Illegal codes (and LINK when BL is not built in) recover to FETCH.
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        LinkW     = 1'b0;
        case (state_reg)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: begin
                ALUOp = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
`ifdef MAINFSM_BL_EN
            LINK: begin
                ResultSrc = 2'b11;
                RegW      = 1'b1;
                LinkW     = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign State = state_reg;

endmodule

// File: tb/tb_mainfsm.sv
// Scoreboard bench for mainfsm: expected state codes are queued per instruction and checked cycle by cycle.
module tb_mainfsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       LinkW;
    logic [3:0] State;

    int n_cmp;
    int n_err;
    int exp_q[$];

    mainfsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .LinkW     (LinkW),
        .State     (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, LinkW}
    function automatic logic [14:0] exp_outs(input int s);
        case (s)
            0:       return 15'b1_0_01_10_10_1_0_0_0_0_0;
            1:       return 15'b0_0_01_10_10_0_0_0_0_0_0;
            2:       return 15'b0_0_00_01_00_0_0_0_0_0_0;
            3:       return 15'b0_1_00_00_00_0_0_0_0_0_0;
            4:       return 15'b0_0_00_00_01_0_1_0_0_0_0;
            5:       return 15'b0_1_00_00_00_0_0_1_0_0_0;
            6:       return 15'b0_0_00_00_00_0_0_0_0_1_0;
            7:       return 15'b0_0_00_01_00_0_0_0_0_1_0;
            8:       return 15'b0_0_00_00_00_0_1_0_0_0_0;
            9:       return 15'b0_0_10_01_10_0_0_0_1_0_0;
            10:      return 15'b0_0_00_00_11_0_1_0_0_0_1;
            default: return 15'b0;
        endcase
    endfunction

    function automatic logic [14:0] act_outs();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp, LinkW};
    endfunction

    // Expected state walk of one instruction, starting from FETCH.
    task automatic push_seq(input logic [1:0] op, input logic [5:0] funct);
        exp_q.push_back(0);
        exp_q.push_back(1);
        case (op)
            2'b00: begin
                exp_q.push_back(funct[5] ? 7 : 6);
                exp_q.push_back(8);
            end
            2'b01: begin
                exp_q.push_back(2);
                if (funct[0]) begin
                    exp_q.push_back(3);
                    exp_q.push_back(4);
                end else begin
                    exp_q.push_back(5);
                end
            end
            2'b10: begin
`ifdef MAINFSM_BL_EN
                if (funct[4]) exp_q.push_back(10);
`endif
                exp_q.push_back(9);
            end
            default: exp_q.push_back(11);
        endcase
    endtask

    // Pops one expected state at a negedge, compares, then advances one cycle.
    // Op/Funct carry the real instruction only where the FSM samples them; elsewhere they are scrambled.
    task automatic step_check(input string name, input logic [1:0] op, input logic [5:0] funct);
        int e;
        e = exp_q.pop_front();
        if (e == 1 || e == 2) begin
            Op    = op;
            Funct = funct;
        end else begin
            Op    = 2'($urandom);
            Funct = 6'($urandom);
        end
        n_cmp++;
        if (State !== 4'(e)) begin
            n_err++;
            $display("FAIL %s state: got %0d expected %0d", name, State, e);
        end
        n_cmp++;
        if (act_outs() !== exp_outs(e)) begin
            n_err++;
            $display("FAIL %s outputs in state %0d: got %b expected %b", name, e, act_outs(), exp_outs(e));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct);
        int cycles;
        push_seq(op, funct);
        cycles = exp_q.size();
        while (exp_q.size() > 0) step_check(name, op, funct);
        $display("instr %-8s op=%b funct=%b cycles=%0d", name, op, funct, cycles);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b000000;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (State !== 4'd0 || act_outs() !== exp_outs(0)) begin
                n_err++;
                $display("FAIL reset cycle %0d: got state %0d outs %b expected state 0 outs %b",
                         i, State, act_outs(), exp_outs(0));
            end
        end
        reset = 1'b0;
        $display("reset held 2 cycles, state=%0d", State);
    endtask

    task automatic test_dp();
        run_instr("dp_reg", 2'b00, 6'b000000);
        run_instr("dp_imm", 2'b00, 6'b100000);
    endtask

    task automatic test_mem();
        run_instr("ldr", 2'b01, 6'b011001);
        run_instr("str", 2'b01, 6'b011000);
    endtask

    task automatic test_branch();
        run_instr("b", 2'b10, 6'b000000);
        run_instr("bl", 2'b10, 6'b010000);
    endtask

    task automatic test_undef();
        run_instr("undef", 2'b11, 6'b101010);
    endtask

    task automatic test_reset_mid();
        push_seq(2'b01, 6'b011001);
        for (int i = 0; i < 3; i++) step_check("ldr_cut", 2'b01, 6'b011001);
        n_cmp++;
        if (State !== 4'd3) begin
            n_err++;
            $display("FAIL reset_mid pre-reset state: got %0d expected 3", State);
        end
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (State !== 4'd0 || act_outs() !== exp_outs(0)) begin
            n_err++;
            $display("FAIL reset_mid: got state %0d outs %b expected state 0 outs %b",
                     State, act_outs(), exp_outs(0));
        end
        reset = 1'b0;
        $display("reset asserted in MEMRD, state=%0d", State);
        run_instr("ldr_rst", 2'b01, 6'b011001);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [1:0] op;
            logic [5:0] funct;
            op    = 2'($urandom);
            funct = 6'($urandom);
            run_instr("random", op, funct);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        @(negedge clk);
        test_reset();
        test_dp();
        test_mem();
        test_branch();
        test_undef();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
